// File: rtl/lms_plant_src.sv
// lms_plant_src: training-stimulus source for an LMS adaptive FIR.
// Emits a pseudo-random excitation x and the output d of a fixed 2-tap plant
// (d = sat((C0*x_n + C1*x_{n-1}) >>> (W1-1))) over a valid/ready handshake.
// Ports:
//   clk, reset (async, active-low)
//   start      - 1-cycle run request, honoured in IDLE/DONE
//   stop       - abort current run, wins over start
//   n_samples  - samples per run, latched at start; 0 = free-run
//   ready      - sink accepts the current sample
//   valid      - x_out/d_out hold a sample
//   x_out      - signed excitation sample
//   d_out      - signed plant output sample
//   busy       - high in LOAD or RUN
//   done       - 1-cycle pulse after the last sample of a counted run
module lms_plant_src #(
  parameter int unsigned W1      = 8,
  parameter int unsigned W2      = 16,
  parameter int          C0      = 64,
  parameter int          C1      = -32,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned X_SHIFT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [15:0]          n_samples,
  input  logic                 ready,
  output logic                 valid,
  output logic signed [W1-1:0] x_out,
  output logic signed [W1-1:0] d_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic signed [W1-1:0] C0_W  = W1'(C0);
  localparam logic signed [W1-1:0] C1_W  = W1'(C1);
  localparam logic signed [W2:0]   D_MAX = (W2+1)'((1 << (W1 - 1)) - 1);
  localparam logic signed [W2:0]   D_MIN = -D_MAX - (W2+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                state_q;
  logic [15:0]           lfsr_q;
  logic [15:0]           cnt_q;
  logic [15:0]           n_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic signed [W1-1:0]  x_q;
  logic signed [W1-1:0]  d_q;

  logic [15:0]           lfsr_src_c;
  logic [15:0]           lfsr_adv_c;
  logic signed [W1-1:0]  xp_src_c;
  logic signed [W1-1:0]  s_c;
  logic signed [W1-1:0]  x_nxt_c;
  logic signed [W1-1:0]  d_nxt_c;
  logic signed [W2-1:0]  p0_c;
  logic signed [W2-1:0]  p1_c;
  logic signed [W2:0]    sum_c;
  logic signed [W2:0]    sh_c;
  logic                  accept_c;
  logic                  last_c;

  // Eight Fibonacci steps of x^16+x^14+x^13+x^11+1, shifting left into bit 0.
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    end
    return r;
  endfunction

  // Next sample: LOAD restarts from SEED with x_{-1}=0; otherwise continue
  // from the live LFSR with the currently presented x as the previous sample.
  always_comb begin
    lfsr_src_c = (state_q == S_LOAD) ? SEED : lfsr_q;
    xp_src_c   = (state_q == S_LOAD) ? '0 : x_q;
    lfsr_adv_c = lfsr_adv8(lfsr_src_c);
    s_c        = lfsr_src_c[W1-1:0];
    x_nxt_c    = s_c >>> X_SHIFT;
    p0_c       = W2'(C0_W) * W2'(x_nxt_c);
    p1_c       = W2'(C1_W) * W2'(xp_src_c);
    sum_c      = (W2+1)'(p0_c) + (W2+1)'(p1_c);
    sh_c       = sum_c >>> (W1 - 1);
    if (sh_c > D_MAX) begin
      d_nxt_c = D_MAX[W1-1:0];
    end else if (sh_c < D_MIN) begin
      d_nxt_c = D_MIN[W1-1:0];
    end else begin
      d_nxt_c = sh_c[W1-1:0];
    end
  end

  assign accept_c = valid_q & ready;
  // n_q == 0 is free-run: the counter wraps and never terminates the run.
  assign last_c   = (n_q != 16'd0) && (cnt_q == n_q - 16'd1);

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      d_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            n_q     <= n_samples;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            state_q <= S_RUN;
            lfsr_q  <= lfsr_adv_c;
            cnt_q   <= '0;
            x_q     <= x_nxt_c;
            d_q     <= d_nxt_c;
            valid_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (accept_c) begin
            cnt_q <= cnt_q + 16'd1;
            if (last_c) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              lfsr_q <= lfsr_adv_c;
              x_q    <= x_nxt_c;
              d_q    <= d_nxt_c;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid = valid_q;
  assign x_out = x_q;
  assign d_out = d_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
